// File: rtl/sha256_padder.sv
// SHA-256/224 message padder: packs a 32-bit byte stream into 512-bit blocks,
// appending the 0x80 marker, zero fill and the 64-bit big-endian bit length.
module sha256_padder #(
   parameter int unsigned BlockWidth = 512,
   parameter int unsigned LenWidth   = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic [31:0]           in_data_i,
   input  logic [2:0]            in_bytes_i,
   input  logic                  in_last_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [BlockWidth-1:0] block_o,
   output logic                  block_valid_o,
   output logic                  block_last_o,
   input  logic                  block_ready_i,
   output logic                  busy_o
);

   localparam int unsigned WordWidth = 32;
   localparam int unsigned NumWords  = BlockWidth / WordWidth;
   localparam int unsigned NumBytes  = BlockWidth / 8;
   localparam int unsigned CntWidth  = LenWidth - 3;
   localparam int unsigned IdxWidth  = $clog2(NumWords);
   localparam int unsigned PosWidth  = $clog2(NumBytes) + 1;
   localparam int unsigned LenStart  = NumBytes - LenWidth / 8;

   localparam logic [1:0] S_COLLECT = 2'd0;
   localparam logic [1:0] S_EMIT    = 2'd1;
   localparam logic [1:0] S_EXTRA   = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [IdxWidth-1:0]   w_q, w_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic                  extra_q, extra_d;
   logic                  pad_first_q, pad_first_d;
   logic [BlockWidth-1:0] block_q, block_d;
   logic                  last_q, last_d;
   logic                  in_ready_q, valid_q, busy_q;

   logic [2:0]            n;
   logic [PosWidth-1:0]   w4;
   logic [PosWidth-1:0]   p;
   logic [CntWidth-1:0]   cnt_last;
   logic [LenWidth-1:0]   len_last;
   logic [BlockWidth-1:0] pad_block;
   logic [BlockWidth-1:0] extra_block;
   logic [7:0]            byte_v;

   // Final-block and trailing-block images, built from the current word position
   always_comb begin
      n        = (in_bytes_i > 3'd4) ? 3'd4 : in_bytes_i;
      w4       = PosWidth'({w_q, 2'b00});
      p        = w4 + PosWidth'(n);
      cnt_last = cnt_q + CntWidth'(n);
      len_last = {cnt_last, 3'b000};
      byte_v   = 8'h00;
      pad_block = '0;
      for (int unsigned b = 0; b < NumBytes; b++) begin
         if (PosWidth'(b) < w4) begin
            byte_v = block_q[BlockWidth-1-8*b -: 8];
         end else if (PosWidth'(b) < p) begin
            byte_v = in_data_i[31-8*(b%4) -: 8];
         end else if (PosWidth'(b) == p) begin
            byte_v = 8'h80;
         end else begin
            byte_v = 8'h00;
         end
         pad_block[BlockWidth-1-8*b -: 8] = byte_v;
      end
      if (p < PosWidth'(LenStart)) begin
         pad_block[LenWidth-1:0] = len_last;
      end

      extra_block = '0;
      extra_block[BlockWidth-1 -: 8] = pad_first_q ? 8'h80 : 8'h00;
      extra_block[LenWidth-1:0]      = {cnt_q, 3'b000};
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      w_d         = w_q;
      cnt_d       = cnt_q;
      extra_d     = extra_q;
      pad_first_d = pad_first_q;
      block_d     = block_q;
      last_d      = last_q;

      unique case (state_q)
         S_COLLECT: begin
            if (in_valid_i) begin
               if (in_last_i) begin
                  block_d = pad_block;
                  cnt_d   = cnt_last;
                  w_d     = '0;
                  state_d = S_EMIT;
                  if (p < PosWidth'(LenStart)) begin
                     last_d      = 1'b1;
                     extra_d     = 1'b0;
                     pad_first_d = 1'b0;
                  end else begin
                     last_d      = 1'b0;
                     extra_d     = 1'b1;
                     pad_first_d = (p == PosWidth'(NumBytes));
                  end
               end else begin
                  for (int unsigned i = 0; i < NumWords; i++) begin
                     if (w_q == IdxWidth'(i)) begin
                        block_d[BlockWidth-1-WordWidth*i -: WordWidth] = in_data_i;
                     end
                  end
                  cnt_d = cnt_q + CntWidth'(4);
                  w_d   = w_q + IdxWidth'(1);
                  if (w_q == IdxWidth'(NumWords - 1)) begin
                     state_d = S_EMIT;
                     last_d  = 1'b0;
                  end
               end
            end
         end
         S_EMIT: begin
            if (block_ready_i) begin
               if (extra_q) begin
                  state_d = S_EXTRA;
                  block_d = extra_block;
                  last_d  = 1'b1;
               end else begin
                  state_d = S_COLLECT;
                  last_d  = 1'b0;
                  if (last_q) begin
                     cnt_d = '0;
                  end
               end
            end
         end
         S_EXTRA: begin
            if (block_ready_i) begin
               state_d = S_COLLECT;
               last_d  = 1'b0;
               cnt_d   = '0;
               extra_d = 1'b0;
            end
         end
         default: begin
            state_d = S_COLLECT;
            last_d  = 1'b0;
         end
      endcase

      // Abort wins over any transfer or handshake in the same cycle
      if (clear_i) begin
         state_d = S_COLLECT;
         w_d     = '0;
         cnt_d   = '0;
         extra_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_COLLECT;
         w_q         <= '0;
         cnt_q       <= '0;
         extra_q     <= 1'b0;
         pad_first_q <= 1'b0;
         block_q     <= '0;
         last_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         w_q         <= w_d;
         cnt_q       <= cnt_d;
         extra_q     <= extra_d;
         pad_first_q <= pad_first_d;
         block_q     <= block_d;
         last_q      <= last_d;
         in_ready_q  <= (state_d == S_COLLECT);
         valid_q     <= (state_d != S_COLLECT);
         busy_q      <= (w_d != '0) || (cnt_d != '0) || (state_d != S_COLLECT);
      end
   end

   assign in_ready_o    = in_ready_q;
   assign block_o       = block_q;
   assign block_valid_o = valid_q;
   assign block_last_o  = last_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: directed length table, hand-timed corner sequences,
// and randomized messages checked against a byte-level padding model.
module tb_sha256_padder;

   typedef logic [7:0] byte_t;
   typedef struct {
      logic [511:0] data;
      logic         last;
   } blk_t;
   typedef struct {
      int          nbytes;
      int          nblocks;
      logic [31:0] w0;
      logic [31:0] w15;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         clear;
   logic [31:0]  in_data;
   logic [2:0]   in_bytes;
   logic         in_last;
   logic         in_valid;
   logic         in_ready;
   logic [511:0] block;
   logic         block_valid;
   logic         block_last;
   logic         block_ready;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   byte_t        msg[$];
   blk_t         exp_q[$];
   int           nblk_seen;
   logic [31:0]  seen_w0;
   logic [31:0]  seen_w15;
   vec_t         vecs[8];

   sha256_padder #(.BlockWidth(512), .LenWidth(64)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .clear_i      (clear),
      .in_data_i    (in_data),
      .in_bytes_i   (in_bytes),
      .in_last_i    (in_last),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .block_o      (block),
      .block_valid_o(block_valid),
      .block_last_o (block_last),
      .block_ready_i(block_ready),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: message bytes + 0x80 + zeros to 56 mod 64 + 64-bit bit length
   function automatic void build_expected();
      byte_t       pad[$];
      logic [63:0] bitlen;
      int          nblk;
      pad    = msg;
      bitlen = 64'(msg.size()) * 64'd8;
      pad.push_back(8'h80);
      while (pad.size() % 64 != 56) pad.push_back(8'h00);
      for (int i = 7; i >= 0; i--) pad.push_back(bitlen[8*i +: 8]);
      exp_q.delete();
      nblk = pad.size() / 64;
      for (int k = 0; k < nblk; k++) begin
         blk_t e;
         for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = pad[64*k+j];
         e.last = (k == nblk - 1);
         exp_q.push_back(e);
      end
   endfunction

   task automatic run_msg(input int nbytes, input bit patterned, input int ready_pct, input int valid_pct);
      int nwords, sent, cyc, nb, idx;
      logic [31:0] w;
      msg.delete();
      for (int i = 0; i < nbytes; i++) msg.push_back(patterned ? byte_t'(i) : byte_t'($urandom));
      build_expected();
      nwords    = (nbytes == 0) ? 1 : (nbytes + 3) / 4;
      sent      = 0;
      cyc       = 0;
      nblk_seen = 0;
      while ((sent < nwords || exp_q.size() > 0) && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         in_valid    = 1'b0;
         block_ready = 1'b0;
         chk("ready_vs_valid", in_ready, !block_valid);
         if (block_valid) begin
            block_ready = ($urandom_range(99) < ready_pct);
            if (block_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_block", block_valid, 1'b0);
               end else begin
                  chk("block_data", block, exp_q[0].data);
                  chk("block_last", block_last, exp_q[0].last);
                  seen_w0  = block[511:480];
                  seen_w15 = block[31:0];
                  nblk_seen++;
                  void'(exp_q.pop_front());
               end
            end
         end else if (in_ready && sent < nwords && $urandom_range(99) < valid_pct) begin
            for (int j = 0; j < 4; j++) begin
               idx = 4 * sent + j;
               w[31-8*j -: 8] = (idx < nbytes) ? msg[idx] : byte_t'($urandom);
            end
            in_data = w;
            in_last = (sent == nwords - 1);
            nb      = nbytes - 4 * sent;
            if (in_last) in_bytes = (nb >= 4) ? 3'($urandom_range(7, 4)) : 3'(nb);
            else         in_bytes = 3'($urandom);
            in_valid = 1'b1;
            sent++;
         end
      end
      if (cyc >= 4000) chk("msg_timeout", 32'(cyc), 32'(0));
      @(negedge clk);
      in_valid    = 1'b0;
      block_ready = 1'b0;
   endtask

   // "abc" with exact one-cycle latency and a clean return to idle
   task automatic abc_check();
      @(negedge clk);
      in_data  = 32'h61626300;
      in_bytes = 3'd3;
      in_last  = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("abc_valid", block_valid, 1'b1);
      chk("abc_last", block_last, 1'b1);
      chk("abc_w0", block[511:480], 32'h61626380);
      chk("abc_mid", block[479:32], 448'h0);
      chk("abc_w15", block[31:0], 32'h00000018);
      chk("abc_in_ready", in_ready, 1'b0);
      chk("abc_busy", busy, 1'b1);
      block_ready = 1'b1;
      @(negedge clk);
      block_ready = 1'b0;
      chk("abc_done_valid", block_valid, 1'b0);
      chk("abc_done_ready", in_ready, 1'b1);
      chk("abc_done_busy", busy, 1'b0);
   endtask

   task automatic send_word(input logic [31:0] d);
      @(negedge clk);
      chk("send_in_ready", in_ready, 1'b1);
      in_data  = d;
      in_bytes = 3'd4;
      in_last  = 1'b0;
      in_valid = 1'b1;
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_data = '0; in_bytes = '0; in_last = 1'b0;
      in_valid = 1'b0; block_ready = 1'b0;
      vecs[0] = '{0,   1, 32'h80000000, 32'h00000000};
      vecs[1] = '{3,   1, 32'h00010280, 32'h00000018};
      vecs[2] = '{55,  1, 32'h00010203, 32'h000001B8};
      vecs[3] = '{56,  2, 32'h00000000, 32'h000001C0};
      vecs[4] = '{63,  2, 32'h00000000, 32'h000001F8};
      vecs[5] = '{64,  2, 32'h80000000, 32'h00000200};
      vecs[6] = '{78,  2, 32'h40414243, 32'h00000270};
      vecs[7] = '{120, 3, 32'h00000000, 32'h000003C0};

      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_valid", block_valid, 1'b0);
      chk("rst_last", block_last, 1'b0);
      chk("rst_block", block, 512'h0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0;

      abc_check();

      // Empty message held under backpressure
      @(negedge clk);
      in_data = 32'hDEADBEEF; in_bytes = 3'd0; in_last = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk("bp_block", block, {32'h80000000, 480'h0});
         chk("bp_valid", block_valid, 1'b1);
         chk("bp_last", block_last, 1'b1);
         chk("bp_in_ready", in_ready, 1'b0);
         @(negedge clk);
      end
      block_ready = 1'b1;
      @(negedge clk);
      block_ready = 1'b0;
      chk("bp_done_valid", block_valid, 1'b0);

      // Directed length table
      foreach (vecs[i]) begin
         run_msg(vecs[i].nbytes, 1'b1, 100, 100);
         chk("tbl_nblocks", 32'(nblk_seen), 32'(vecs[i].nblocks));
         chk("tbl_w0", seen_w0, vecs[i].w0);
         chk("tbl_w15", seen_w15, vecs[i].w15);
      end

      // clear_i during EMIT, simultaneous with the downstream handshake
      for (int i = 0; i < 16; i++) send_word(32'(i));
      @(negedge clk);
      in_valid = 1'b0;
      chk("clr_emit_valid", block_valid, 1'b1);
      clear = 1'b1; block_ready = 1'b1;
      @(negedge clk);
      clear = 1'b0; block_ready = 1'b0;
      chk("clr_valid", block_valid, 1'b0);
      chk("clr_in_ready", in_ready, 1'b1);
      chk("clr_busy", busy, 1'b0);

      // clear_i with a transfer in the same cycle discards that word
      send_word(32'h11111111);
      send_word(32'h22222222);
      @(negedge clk);
      in_data = 32'h33333333; in_last = 1'b0; in_valid = 1'b1; clear = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; clear = 1'b0;
      chk("clr_xfer_busy", busy, 1'b0);

      // Asynchronous reset mid-COLLECT
      send_word(32'hAAAAAAAA);
      send_word(32'hBBBBBBBB);
      @(negedge clk);
      in_valid = 1'b0;
      chk("mid_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      chk("arst_block", block, 512'h0);
      chk("arst_valid", block_valid, 1'b0);
      chk("arst_in_ready", in_ready, 1'b1);
      chk("arst_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      abc_check();

      // Randomized messages with random handshake pressure
      for (int t = 0; t < 30; t++) begin
         run_msg(int'($urandom_range(200, 0)), 1'b0, 60, 70);
         chk("rand_idle_busy", busy, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
- Upstream message-formatting stage for the SHA-256/224 core.
- Accepts a byte-aligned message as a stream of 32-bit words with a valid/ready handshake.
- Applies FIPS 180-4 padding: a 0x80 byte, zero fill, then the 64-bit big-endian bit length.
- Presents complete 512-bit blocks on a second valid/ready handshake, which the core's block loader consumes one block at a time.

Parameters:
BlockWidth, 512, output block width in bits; only 512 is supported.
LenWidth, 64, width of the appended message-length field in bits.

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-high
clear_i  input  1  synchronous abort; discards the message in progress and returns to COLLECT
in_data_i  input  32  message word; byte 0 of the word is in_data_i[31:24]
in_bytes_i  input  3  valid bytes in the word, 0..4; sampled only when in_last_i=1
in_last_i  input  1  final word of the message
in_valid_i  input  1  input word valid
in_ready_o  output  1  padder can accept a word
block_o  output  512  block; word w is at block_o[511-32w -: 32]
block_valid_o  output  1  block_o holds a complete block
block_last_o  output  1  block_o is the final block of the message
block_ready_i  input  1  downstream accepts the block
busy_o  output  1  a message is in progress (words accepted or blocks pending)

Behaviour:
- Reset (rst_i=1, asynchronous):
  - state=COLLECT, word index=0, byte counter=0.
  - block register=0, extra-block-pending flag=0.
  - Outputs: in_ready_o=1, block_valid_o=0, block_last_o=0, block_o=0, busy_o=0.
- States: COLLECT, EMIT, EXTRA.
- COLLECT:
  - in_ready_o=1.
  - A transfer is in_valid_i&in_ready_o.
  - Each transfer writes the word at index w and increments w. A non-last word counts 4 bytes.
  - Non-last transfer at w=15: next cycle enters EMIT with block_last_o=0, and w wraps to 0.
  - Last transfer with n bytes (in_bytes_i; values >4 saturate to 4; 0 means no data bytes in this word):
    - Unused bytes of the word are cleared.
    - Pad position p=4w+n.
    - Length L = (total bytes x 8) mod 2^64, computed in the same cycle including n.
    - p<=55: 0x80 at byte p, zero fill, L at bytes 56..63. Enter EMIT with block_last_o=1.
    - 56<=p<=63: 0x80 at byte p, zero fill to byte 63. Enter EMIT with block_last_o=0 and set the extra flag.
    - p=64: data only. Enter EMIT with block_last_o=0 and set the extra flag.
  - The padded block is registered in the same edge as the last transfer, so block_valid_o rises the next cycle.
- EMIT:
  - block_valid_o=1, in_ready_o=0.
  - block_o and block_last_o stay stable until block_ready_i=1.
  - On handshake:
    - extra flag set: go to EXTRA. The block is rebuilt as all zeros, with 0x80 at byte 0 only if p was 64, and L at bytes 56..63.
    - otherwise, last block: return to COLLECT and clear the byte counter.
    - otherwise, not last: return to COLLECT and keep the byte counter.
- EXTRA:
  - block_valid_o=1, block_last_o=1, in_ready_o=0.
  - On handshake: COLLECT, clear the byte counter and extra flag.
- Latency: the first block-valid cycle follows the accepting edge by one cycle. No combinational path exists from in_valid_i or block_ready_i to any output.
- Byte counter: 61 bits and wraps silently. L is the counter shifted left by 3.
- busy_o=1 when w!=0, the byte counter is nonzero, or the state is not COLLECT.
- clear_i:
  - Highest priority after rst_i, in any state, including simultaneously with a handshake.
  - Returns to COLLECT and clears w, the counter and the extra flag.
  - block_valid_o=0 the next cycle.
  - A transfer or handshake in the same cycle as clear_i is discarded.
- Empty message (first word has in_last_i=1, n=0) produces block 0x80 followed by zeros, with L=0.

Test Plan:
- "abc": one word 0x61626300, n=3, last -> one block; word0=0x61626380, words1..14=0, word15=0x00000018; block_last_o=1 one cycle after the transfer.
- 56-byte message (14 words, last n=4) -> block1: data, word14=0x80000000, word15=0, last=0; block2: zeros, word14=0, word15=0x000001C0, last=1.
- 64-byte message (16 words, last n=4) -> block1 = raw data with last=0; block2: word0=0x80000000, word15=0x00000200, last=1.
- Empty message (last, n=0) -> word0=0x80000000, all else 0, last=1. Backpressure variant: hold block_ready_i=0 for 5 cycles -> block_o and block_valid_o stable, in_ready_o=0 throughout.
- 20-word message with last n=2 -> block1 (16 words) then block2: words0..3 data, word3 bytes 2..3 = 0x80,0x00; length word15=0x00000270 (78 bytes x 8 = 624).
- clear_i asserted in EMIT, then rst_i asserted mid-COLLECT -> next cycle block_valid_o=0, in_ready_o=1, busy_o=0; a following "abc" yields the correct single block.
